// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types, op codes and lane helpers for the MEM stage SRAM controller.
package mem_sram_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned BE_W     = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;
  typedef logic [BE_W-1:0]     sram_bsel_t;

  localparam alu_op_t EXE_NOP_OP = 8'b0000_0000;
  localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Write-back bundle handed to the DF stage.
  typedef struct packed {
    alu_op_t             alu_op;
    logic                gpr_we;
    logic [REG_AW-1:0]   gpr_waddr;
    logic [DATA_W-1:0]   gpr_wdata;
    sram_bsel_t          be;
  } wb_bundle_t;

  localparam wb_bundle_t WB_BUBBLE = '{
    alu_op:    EXE_NOP_OP,
    gpr_we:    1'b0,
    gpr_waddr: '0,
    gpr_wdata: '0,
    be:        '0
  };

  function automatic logic is_load(input alu_op_t op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input alu_op_t op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic is_mem_op(input alu_op_t op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_half(input alu_op_t op);
    return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  endfunction

  function automatic logic is_word(input alu_op_t op);
    return op inside {EXE_LW_OP, EXE_SW_OP};
  endfunction

  function automatic logic misaligned(input alu_op_t op, input logic [1:0] a);
    return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
  endfunction

  function automatic sram_bsel_t byte_en(input alu_op_t op, input logic [1:0] a);
    if (is_word(op))      return 4'b1111;
    else if (is_half(op)) return a[1] ? 4'b1100 : 4'b0011;
    else if (is_mem_op(op)) return sram_bsel_t'(4'b0001 << a);
    else                  return 4'b0000;
  endfunction

  // Replicate store data across every lane; the byte enables pick the live ones.
  function automatic logic [DATA_W-1:0] store_lanes(input alu_op_t op, input logic [DATA_W-1:0] d);
    case (op)
      EXE_SB_OP: return {4{d[7:0]}};
      EXE_SH_OP: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects and sign/zero-extends the addressed byte or half of an SRAM read word.
module mem_load_align
  import mem_sram_ctrl_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [1:0]          a,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   wdata_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{a, 3'b000} +: 8];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    wdata_c  = rdata;
    case (op)
      EXE_LB_OP:  wdata_c = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: wdata_c = {24'd0, byte_sel};
      EXE_LH_OP:  wdata_c = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: wdata_c = {16'd0, half_sel};
      default:    wdata_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MIPS MEM stage: fixed wait-state async SRAM access, load alignment and the
// registered write-back bundle, stalling upstream while an access is in flight.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                VALID_I,
  input  logic [ALU_OP_W-1:0] ALU_OP_I,
  input  logic                GPR_WE_I,
  input  logic [REG_AW-1:0]   GPR_WADDR_I,
  input  logic [DATA_W-1:0]   GPR_WDATA_I,
  input  logic [DATA_W-1:0]   MEM_SDATA_I,
  output logic [SRAM_AW-1:0]  SRAM_ADDR_O,
  output logic [DATA_W-1:0]   SRAM_WDATA_O,
  input  logic [DATA_W-1:0]   SRAM_RDATA_I,
  output logic                SRAM_CE_N_O,
  output logic                SRAM_OE_N_O,
  output logic                SRAM_WE_N_O,
  output logic [BE_W-1:0]     SRAM_BE_N_O,
  output logic                STALL_REQ_O,
  output logic                ADDR_ERR_O,
  output logic [ALU_OP_W-1:0] ALU_OP_O,
  output logic                GPR_WE_O,
  output logic [REG_AW-1:0]   GPR_WADDR_O,
  output logic [DATA_W-1:0]   GPR_WDATA_O,
  output logic [BE_W-1:0]     SRAM_DATA_BE_O
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  alu_op_t            op_q, op_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [REG_AW-1:0]  waddr_q, waddr_d;
  sram_bsel_t         be_q, be_d;
  wb_bundle_t         wb_q, wb_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  sram_bsel_t         be_n_q, be_n_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]  sram_wdata_q, sram_wdata_d;
  logic               addr_err_q, addr_err_d;

  logic              is_mem_c;
  logic              mis_c;
  logic              accept_c;
  logic              last_c;
  logic [DATA_W-1:0] load_data_c;

  mem_load_align u_load_align (
    .op      (op_q),
    .a       (addr_q[1:0]),
    .rdata   (SRAM_RDATA_I),
    .wdata_c (load_data_c)
  );

  assign is_mem_c = is_mem_op(ALU_OP_I);
  assign mis_c    = misaligned(ALU_OP_I, GPR_WDATA_I[1:0]);
  assign accept_c = !RST && (state_q == ST_IDLE) && VALID_I && is_mem_c && !mis_c;
  assign last_c   = (state_q == ST_ACCESS) && (cnt_q == CW'(WAIT_CYCLES - 1));

  // Stall drops in the final access cycle so EX advances on the write-back edge.
  assign STALL_REQ_O = accept_c || (!RST && (state_q == ST_ACCESS) && !last_c);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    waddr_d      = waddr_q;
    be_d         = be_q;
    wb_d         = WB_BUBBLE;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    be_n_d       = '1;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = '0;
    addr_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (VALID_I) begin
          if (!is_mem_c) begin
            wb_d.alu_op    = ALU_OP_I;
            wb_d.gpr_we    = GPR_WE_I;
            wb_d.gpr_waddr = GPR_WADDR_I;
            wb_d.gpr_wdata = GPR_WDATA_I;
          end else if (mis_c) begin
            addr_err_d = 1'b1;
          end else begin
            state_d      = ST_ACCESS;
            cnt_d        = '0;
            op_d         = ALU_OP_I;
            addr_d       = GPR_WDATA_I;
            waddr_d      = GPR_WADDR_I;
            be_d         = byte_en(ALU_OP_I, GPR_WDATA_I[1:0]);
            ce_n_d       = 1'b0;
            oe_n_d       = !is_load(ALU_OP_I);
            we_n_d       = !is_store(ALU_OP_I);
            be_n_d       = ~byte_en(ALU_OP_I, GPR_WDATA_I[1:0]);
            sram_addr_d  = GPR_WDATA_I[SRAM_AW+1:2];
            sram_wdata_d = is_store(ALU_OP_I) ? store_lanes(ALU_OP_I, MEM_SDATA_I) : '0;
          end
        end
      end
      ST_ACCESS: begin
        if (last_c) begin
          state_d        = ST_IDLE;
          wb_d.alu_op    = op_q;
          wb_d.gpr_we    = is_load(op_q);
          wb_d.gpr_waddr = waddr_q;
          wb_d.gpr_wdata = is_load(op_q) ? load_data_c : addr_q;
          wb_d.be        = be_q;
        end else begin
          cnt_d        = cnt_q + CW'(1);
          ce_n_d       = 1'b0;
          oe_n_d       = !is_load(op_q);
          we_n_d       = !is_store(op_q);
          be_n_d       = ~be_q;
          sram_wdata_d = sram_wdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= EXE_NOP_OP;
      addr_q       <= '0;
      waddr_q      <= '0;
      be_q         <= '0;
      wb_q         <= WB_BUBBLE;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= '1;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      waddr_q      <= waddr_d;
      be_q         <= be_d;
      wb_q         <= wb_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign SRAM_ADDR_O    = sram_addr_q;
  assign SRAM_WDATA_O   = sram_wdata_q;
  assign SRAM_CE_N_O    = ce_n_q;
  assign SRAM_OE_N_O    = oe_n_q;
  assign SRAM_WE_N_O    = we_n_q;
  assign SRAM_BE_N_O    = be_n_q;
  assign ADDR_ERR_O     = addr_err_q;
  assign ALU_OP_O       = wb_q.alu_op;
  assign GPR_WE_O       = wb_q.gpr_we;
  assign GPR_WADDR_O    = wb_q.gpr_waddr;
  assign GPR_WDATA_O    = wb_q.gpr_wdata;
  assign SRAM_DATA_BE_O = wb_q.be;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: expected write-back bundles are queued on
// issue and popped when the stage delivers its output.
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  localparam logic [7:0] ADDU = 8'b0010_0001;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VALID_I;
  logic [7:0]  ALU_OP_I;
  logic        GPR_WE_I;
  logic [4:0]  GPR_WADDR_I;
  logic [31:0] GPR_WDATA_I;
  logic [31:0] MEM_SDATA_I;
  logic [19:0] SRAM_ADDR_O;
  logic [31:0] SRAM_WDATA_O;
  logic [31:0] SRAM_RDATA_I;
  logic        SRAM_CE_N_O, SRAM_OE_N_O, SRAM_WE_N_O;
  logic [3:0]  SRAM_BE_N_O;
  logic        STALL_REQ_O, ADDR_ERR_O;
  logic [7:0]  ALU_OP_O;
  logic        GPR_WE_O;
  logic [4:0]  GPR_WADDR_O;
  logic [31:0] GPR_WDATA_O;
  logic [3:0]  SRAM_DATA_BE_O;

  mem_sram_ctrl #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut (
    .CLK(CLK), .RST(RST), .VALID_I(VALID_I), .ALU_OP_I(ALU_OP_I),
    .GPR_WE_I(GPR_WE_I), .GPR_WADDR_I(GPR_WADDR_I), .GPR_WDATA_I(GPR_WDATA_I),
    .MEM_SDATA_I(MEM_SDATA_I), .SRAM_ADDR_O(SRAM_ADDR_O), .SRAM_WDATA_O(SRAM_WDATA_O),
    .SRAM_RDATA_I(SRAM_RDATA_I), .SRAM_CE_N_O(SRAM_CE_N_O), .SRAM_OE_N_O(SRAM_OE_N_O),
    .SRAM_WE_N_O(SRAM_WE_N_O), .SRAM_BE_N_O(SRAM_BE_N_O), .STALL_REQ_O(STALL_REQ_O),
    .ADDR_ERR_O(ADDR_ERR_O), .ALU_OP_O(ALU_OP_O), .GPR_WE_O(GPR_WE_O),
    .GPR_WADDR_O(GPR_WADDR_O), .GPR_WDATA_O(GPR_WDATA_O), .SRAM_DATA_BE_O(SRAM_DATA_BE_O)
  );

  always #5 CLK = ~CLK;

  localparam logic [49:0] BUBBLE = 50'd0;
  localparam logic [113:0] RESET_VEC = {8'h00, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b1,
                                        4'hF, 20'd0, 32'd0, 1'b0, 1'b0};

  logic [49:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  int obs_edges, obs_stall, obs_ce, obs_oe, obs_we;
  logic [19:0] obs_addr;
  logic [3:0]  obs_be_n;
  logic [31:0] obs_wdata;

  function automatic logic [49:0] out_vec();
    return {ALU_OP_O, GPR_WE_O, GPR_WADDR_O, GPR_WDATA_O, SRAM_DATA_BE_O};
  endfunction

  function automatic logic [113:0] all_vec();
    return {ALU_OP_O, GPR_WE_O, GPR_WADDR_O, GPR_WDATA_O, SRAM_DATA_BE_O, SRAM_CE_N_O,
            SRAM_OE_N_O, SRAM_WE_N_O, SRAM_BE_N_O, SRAM_ADDR_O, SRAM_WDATA_O,
            STALL_REQ_O, ADDR_ERR_O};
  endfunction

  // Reference model of the write-back bundle {op, we, waddr, wdata, be}.
  function automatic logic [49:0] model(input logic [7:0] op, input logic we,
                                        input logic [4:0] wa, input logic [31:0] a,
                                        input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (a[1:0] * 8));
    h = 16'(rd >> (a[1] * 16));
    case (op)
      EXE_LB_OP:  return {op, 1'b1, wa, {{24{b[7]}}, b}, 4'(4'b0001 << a[1:0])};
      EXE_LBU_OP: return {op, 1'b1, wa, {24'd0, b}, 4'(4'b0001 << a[1:0])};
      EXE_SB_OP:  return {op, 1'b0, wa, a, 4'(4'b0001 << a[1:0])};
      EXE_LH_OP:  return a[0] ? BUBBLE : {op, 1'b1, wa, {{16{h[15]}}, h}, a[1] ? 4'b1100 : 4'b0011};
      EXE_LHU_OP: return a[0] ? BUBBLE : {op, 1'b1, wa, {16'd0, h}, a[1] ? 4'b1100 : 4'b0011};
      EXE_SH_OP:  return a[0] ? BUBBLE : {op, 1'b0, wa, a, a[1] ? 4'b1100 : 4'b0011};
      EXE_LW_OP:  return (a[1:0] != 0) ? BUBBLE : {op, 1'b1, wa, rd, 4'b1111};
      EXE_SW_OP:  return (a[1:0] != 0) ? BUBBLE : {op, 1'b0, wa, a, 4'b1111};
      default:    return {op, we, wa, a, 4'b0000};
    endcase
  endfunction

  // Present one EX bundle, hold it while stalled, return after the output edge.
  task automatic issue(input logic [7:0] op, input logic we, input logic [4:0] wa,
                       input logic [31:0] a, input logic [31:0] sd);
    bit done;
    @(negedge CLK);
    VALID_I = 1'b1; ALU_OP_I = op; GPR_WE_I = we; GPR_WADDR_I = wa;
    GPR_WDATA_I = a; MEM_SDATA_I = sd;
    sb_q.push_back(model(op, we, wa, a, SRAM_RDATA_I));
    obs_edges = 0; obs_stall = 0; obs_ce = 0; obs_oe = 0; obs_we = 0;
    obs_addr = '0; obs_be_n = '1; obs_wdata = '0;
    done = 1'b0;
    while (!done && obs_edges < 20) begin
      #1;
      if (STALL_REQ_O) obs_stall++;
      if (!SRAM_CE_N_O) begin
        obs_ce++; obs_addr = SRAM_ADDR_O; obs_be_n = SRAM_BE_N_O; obs_wdata = SRAM_WDATA_O;
      end
      if (!SRAM_OE_N_O) obs_oe++;
      if (!SRAM_WE_N_O) obs_we++;
      done = !STALL_REQ_O;
      @(posedge CLK);
      obs_edges++;
      if (!done) @(negedge CLK);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout op=%h stall still high after %0d edges", op, obs_edges);
    end
    #1;
    VALID_I = 1'b0; ALU_OP_I = EXE_NOP_OP; GPR_WE_I = 1'b0;
  endtask

  task automatic test_reset();
    logic [113:0] got;
    RST = 1'b1; VALID_I = 1'b0; ALU_OP_I = EXE_NOP_OP; GPR_WE_I = 1'b0;
    GPR_WADDR_I = '0; GPR_WDATA_I = '0; MEM_SDATA_I = '0; SRAM_RDATA_I = '0;
    repeat (2) @(posedge CLK);
    #1;
    got = all_vec();
    checks++;
    if (got !== RESET_VEC) begin
      errors++; $display("FAIL reset_state got %h exp %h", got, RESET_VEC);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_alu();
    logic [49:0] exp, got;
    logic [7:0] ops[4] = '{8'b0010_0001, 8'b0010_0101, 8'b0010_0110, 8'b0010_1010};
    issue(ADDU, 1'b1, 5'd3, 32'h0000_1234, 32'h0);
    exp = sb_q.pop_front(); got = out_vec();
    checks++;
    if (got !== exp || got !== {ADDU, 1'b1, 5'd3, 32'h0000_1234, 4'b0000}) begin
      errors++; $display("FAIL alu_addu got %h exp %h", got, exp);
    end
    checks++;
    if (obs_stall != 0 || obs_edges != 1) begin
      errors++; $display("FAIL alu_nostall stall=%0d edges=%0d exp 0/1", obs_stall, obs_edges);
    end
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 1'($urandom), 5'($urandom), $urandom, $urandom);
      exp = sb_q.pop_front(); got = out_vec();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL alu_op%0d got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_bubble();
    logic [49:0] exp, got;
    issue(ADDU, 1'b1, 5'd7, 32'hCAFE_0001, 32'h0);
    void'(sb_q.pop_front());
    sb_q.push_back(BUBBLE);
    @(posedge CLK); #1;
    exp = sb_q.pop_front(); got = out_vec();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL bubble got %h exp %h", got, exp);
    end
  endtask

  task automatic test_store();
    logic [49:0] exp, got;
    issue(EXE_SW_OP, 1'b0, 5'd4, 32'h0000_0100, 32'hDEAD_BEEF);
    exp = sb_q.pop_front(); got = out_vec();
    checks++;
    if (got !== exp || got[4:0] !== 5'b0_1111) begin
      errors++; $display("FAIL sw_bundle got %h exp %h", got, exp);
    end
    checks++;
    if (obs_addr !== 20'h00040 || obs_be_n !== 4'b0000 || obs_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_sram addr=%h be_n=%b wdata=%h exp 00040/0000/deadbeef",
                         obs_addr, obs_be_n, obs_wdata);
    end
    checks++;
    if (obs_we != 2 || obs_oe != 0 || obs_ce != 2) begin
      errors++; $display("FAIL sw_strobes we=%0d oe=%0d ce=%0d exp 2/0/2", obs_we, obs_oe, obs_ce);
    end
    checks++;
    if (obs_stall != 2 || obs_edges != 3) begin
      errors++; $display("FAIL sw_timing stall=%0d edges=%0d exp 2/3", obs_stall, obs_edges);
    end
    checks++;
    if ({SRAM_CE_N_O, SRAM_WE_N_O, SRAM_BE_N_O} !== 6'b11_1111) begin
      errors++; $display("FAIL sw_release got %b exp 111111",
                         {SRAM_CE_N_O, SRAM_WE_N_O, SRAM_BE_N_O});
    end
  endtask

  task automatic test_load();
    logic [49:0] exp, got;
    logic [7:0]  lops[5]  = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    logic [31:0] laddr[5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h204};
    logic [31:0] lreq[5]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_0000,
                              32'h80FF_0000};
    SRAM_RDATA_I = 32'h80FF_0000;
    for (int i = 0; i < 5; i++) begin
      issue(lops[i], 1'b1, 5'(i + 8), laddr[i], 32'h0);
      exp = sb_q.pop_front(); got = out_vec();
      checks++;
      if (got !== exp || GPR_WDATA_O !== lreq[i] || GPR_WE_O !== 1'b1) begin
        errors++; $display("FAIL load%0d got %h exp %h data_req %h", i, got, exp, lreq[i]);
      end
      checks++;
      if (obs_oe != 2 || obs_we != 0 || obs_edges != 3) begin
        errors++; $display("FAIL load%0d_strobes oe=%0d we=%0d edges=%0d exp 2/0/3",
                           i, obs_oe, obs_we, obs_edges);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [49:0] exp, got;
    logic [7:0]  mops[2]  = '{EXE_LW_OP, EXE_SH_OP};
    logic [31:0] maddr[2] = '{32'h102, 32'h101};
    for (int i = 0; i < 2; i++) begin
      issue(mops[i], 1'b1, 5'd9, maddr[i], 32'h1);
      exp = sb_q.pop_front(); got = out_vec();
      checks++;
      if (got !== exp || got !== BUBBLE) begin
        errors++; $display("FAIL mis%0d_bundle got %h exp %h", i, got, exp);
      end
      checks++;
      if (ADDR_ERR_O !== 1'b1 || obs_ce != 0 || obs_stall != 0 || obs_edges != 1) begin
        errors++; $display("FAIL mis%0d_err err=%b ce=%0d stall=%0d edges=%0d exp 1/0/0/1",
                           i, ADDR_ERR_O, obs_ce, obs_stall, obs_edges);
      end
      @(posedge CLK); #1;
      checks++;
      if (ADDR_ERR_O !== 1'b0 || SRAM_CE_N_O !== 1'b1) begin
        errors++; $display("FAIL mis%0d_pulse err=%b ce_n=%b exp 0/1", i, ADDR_ERR_O, SRAM_CE_N_O);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [113:0] got;
    SRAM_RDATA_I = 32'h1357_9BDF;
    @(negedge CLK);
    VALID_I = 1'b1; ALU_OP_I = EXE_LW_OP; GPR_WE_I = 1'b1; GPR_WADDR_I = 5'd12;
    GPR_WDATA_I = 32'h100;
    @(posedge CLK); @(negedge CLK); #1;
    checks++;
    if (SRAM_OE_N_O !== 1'b0 || SRAM_CE_N_O !== 1'b0 || STALL_REQ_O !== 1'b1) begin
      errors++; $display("FAIL rstmid_access oe_n=%b ce_n=%b stall=%b exp 0/0/1",
                         SRAM_OE_N_O, SRAM_CE_N_O, STALL_REQ_O);
    end
    @(posedge CLK); @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    got = all_vec();
    checks++;
    if (got !== RESET_VEC) begin
      errors++; $display("FAIL rstmid_state got %h exp %h", got, RESET_VEC);
    end
    @(negedge CLK);
    RST = 1'b0; VALID_I = 1'b0; ALU_OP_I = EXE_NOP_OP; GPR_WE_I = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (GPR_WE_O !== 1'b0 || SRAM_CE_N_O !== 1'b1) begin
      errors++; $display("FAIL rstmid_nowb we=%b ce_n=%b exp 0/1", GPR_WE_O, SRAM_CE_N_O);
    end
    issue(ADDU, 1'b1, 5'd1, 32'h55, 32'h0);
    void'(sb_q.pop_front());
    checks++;
    if (obs_edges != 1 || GPR_WDATA_O !== 32'h55) begin
      errors++; $display("FAIL rstmid_idle edges=%0d data=%h exp 1/00000055", obs_edges, GPR_WDATA_O);
    end
  endtask

  task automatic test_back_to_back();
    logic [49:0] exp, got;
    SRAM_RDATA_I = 32'h1122_AB44;
    issue(EXE_SB_OP, 1'b0, 5'd2, 32'h101, 32'h0000_00AB);
    exp = sb_q.pop_front(); got = out_vec();
    checks++;
    if (got !== exp || SRAM_DATA_BE_O !== 4'b0010) begin
      errors++; $display("FAIL b2b_sb_bundle got %h exp %h", got, exp);
    end
    checks++;
    if (obs_wdata !== 32'hABAB_ABAB || obs_be_n !== 4'b1101 || obs_we != 2) begin
      errors++; $display("FAIL b2b_sb_sram wdata=%h be_n=%b we=%0d exp ababab ab/1101/2",
                         obs_wdata, obs_be_n, obs_we);
    end
    issue(EXE_LW_OP, 1'b1, 5'd6, 32'h100, 32'h0);
    exp = sb_q.pop_front(); got = out_vec();
    checks++;
    if (got !== exp || GPR_WDATA_O !== 32'h1122_AB44) begin
      errors++; $display("FAIL b2b_lw got %h exp %h", got, exp);
    end
    checks++;
    if (obs_edges != 3 || obs_oe != 2 || obs_addr !== 20'h00040) begin
      errors++; $display("FAIL b2b_lw_timing edges=%0d oe=%0d addr=%h exp 3/2/00040",
                         obs_edges, obs_oe, obs_addr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_bubble();
    test_store();
    test_load();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d entries exp 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
